// File: rtl/bus_datapath_seq.sv
// Self-sequencing single-bus datapath: register file, HI/LO, Y and Z.
// Each accepted command runs T0 -> T1 -> (MD) -> T2 on the shared bus.
// MUL/DIV iterate over WIDTH cycles in MD using one shared 2*WIDTH shift register.
module bus_datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [$clog2(NREG)-1:0]  cmd_ra,
    input  logic [$clog2(NREG)-1:0]  cmd_rb,
    input  logic [$clog2(NREG)-1:0]  cmd_rc,
    input  logic [WIDTH-1:0]         cmd_imm,
    output logic                     done,
    output logic [WIDTH-1:0]         bus_out,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_MD,
        S_T2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_ROR  = 4'd6,
        OP_ROL  = 4'd7,
        OP_NEG  = 4'd8,
        OP_NOT  = 4'd9,
        OP_ADDI = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12,
        OP_MFHI = 4'd13,
        OP_MFLO = 4'd14,
        OP_NOP  = 4'd15
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [RW-1:0]      ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic [WIDTH-1:0]   regs_d [NREG];
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   y_q, y_d, z_q, z_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_res;
    logic [SW-1:0]      amt;
    logic [2*WIDTH-1:0] ror_w, rol_w;
    logic [WIDTH-1:0]   mag_y, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh, div_tr;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = done_q;
    assign bus_out   = bus;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_data  = regs_q[dbg_addr];

    // Shared-bus source select per sequencing step
    always_comb begin
        bus = '0;
        case (state_q)
            S_T0: bus = (op_q == OP_ADDI && rb_q == '0) ? '0 : regs_q[rb_q];
            S_T1: bus = (op_q == OP_ADDI) ? imm_q : regs_q[rc_q];
            S_T2: begin
                case (op_q)
                    OP_MUL:  bus = prod_fix[WIDTH-1:0];
                    OP_DIV:  bus = quot;
                    OP_MFHI: bus = hi_q;
                    OP_MFLO: bus = lo_q;
                    default: bus = z_q;
                endcase
            end
            default: bus = '0;
        endcase
    end

    // ALU: Y combined with the T1 bus value
    always_comb begin
        amt   = bus[SW-1:0];
        ror_w = {y_q, y_q} >> amt;
        rol_w = {y_q, y_q} << amt;
        case (op_q)
            OP_ADD, OP_ADDI: alu_res = y_q + bus;
            OP_SUB:          alu_res = y_q - bus;
            OP_AND:          alu_res = y_q & bus;
            OP_OR:           alu_res = y_q | bus;
            OP_SHR:          alu_res = y_q >> amt;
            OP_SHL:          alu_res = y_q << amt;
            OP_ROR:          alu_res = ror_w[WIDTH-1:0];
            OP_ROL:          alu_res = rol_w[2*WIDTH-1:WIDTH];
            OP_NEG:          alu_res = -y_q;
            OP_NOT:          alu_res = ~y_q;
            default:         alu_res = '0;
        endcase
    end

    // Multiply/divide iteration step and signed result fix-up
    always_comb begin
        mag_y = y_q[WIDTH-1] ? -y_q : y_q;
        mag_b = bus[WIDTH-1] ? -bus : bus;

        // shift-add: p = {acc, multiplier}, m = multiplicand
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_next = {mul_sum, p_q[WIDTH-1:1]};

        // restoring: p = {remainder, dividend/quotient}, m = divisor
        div_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_tr = div_sh - {1'b0, m_q};
        if (div_tr[WIDTH])
            div_next = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        else
            div_next = {div_tr[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

        prod_fix = (sa_q ^ sb_q) ? -p_q : p_q;
        if (m_q == '0) begin
            quot = '1;
            rem  = y_q;
        end else begin
            quot = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            rem  = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer next-state and register-update logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        imm_d   = imm_q;
        regs_d  = regs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        y_d     = y_q;
        z_d     = z_q;
        p_d     = p_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    rc_d    = cmd_rc;
                    imm_d   = cmd_imm;
                    state_d = S_T0;
                end
            end
            S_T0: begin
                y_d     = bus;
                state_d = S_T1;
            end
            S_T1: begin
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    sa_d    = y_q[WIDTH-1];
                    sb_d    = bus[WIDTH-1];
                    m_d     = (op_q == OP_MUL) ? mag_y : mag_b;
                    p_d     = (op_q == OP_MUL) ? {{WIDTH{1'b0}}, mag_b}
                                               : {{WIDTH{1'b0}}, mag_y};
                    cnt_d   = '0;
                    state_d = S_MD;
                end else begin
                    z_d     = alu_res;
                    state_d = S_T2;
                end
            end
            S_MD: begin
                p_d   = (op_q == OP_MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH - 1))
                    state_d = S_T2;
            end
            S_T2: begin
                case (op_q)
                    OP_MUL: begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    OP_DIV: begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                    OP_NOP: ;
                    default: regs_d[ra_q] = bus;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_T2);
    end

    // State, IR and datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= '0;
            for (int unsigned i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            p_q     <= '0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            imm_q   <= imm_d;
            regs_q  <= regs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
            z_q     <= z_d;
            p_q     <= p_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Testbench for bus_datapath_seq: directed scenarios plus random commands
// checked against an arithmetic reference model of the register state.
module tb_bus_datapath_seq;

    localparam int W    = 32;
    localparam int NREG = 16;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
    logic [31:0] cmd_imm = '0;
    logic        done;
    logic [31:0] bus_out, hi, lo, dbg_data;
    logic [3:0]  dbg_addr = '0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mr [NREG];
    logic [31:0] mhi, mlo;

    always #5 clk = ~clk;

    bus_datapath_seq #(.WIDTH(W), .NREG(NREG)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rc    (cmd_rc),
        .cmd_imm   (cmd_imm),
        .done      (done),
        .bus_out   (bus_out),
        .hi        (hi),
        .lo        (lo),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) mr[i] = '0;
        mhi = '0;
        mlo = '0;
    endfunction

    // Reference semantics: returns the value the T2 bus should carry
    function automatic logic [31:0] model_exec(input logic [3:0] op, input logic [3:0] ra,
                                               input logic [3:0] rb, input logic [3:0] rc,
                                               input logic [31:0] imm);
        logic [31:0] a, b, res;
        longint sa, sb, q, r, p;
        logic [63:0] pw;
        int amt;
        a   = (op == 4'd10 && rb == 4'd0) ? 32'd0 : mr[rb];
        b   = (op == 4'd10) ? imm : mr[rc];
        amt = int'(b[4:0]);
        res = '0;
        case (op)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = a >> amt;
            4'd5:  res = a << amt;
            4'd6:  begin res = a; for (int i = 0; i < amt; i++) res = {res[0], res[31:1]}; end
            4'd7:  begin res = a; for (int i = 0; i < amt; i++) res = {res[30:0], res[31]}; end
            4'd8:  res = -a;
            4'd9:  res = ~a;
            4'd10: res = a + b;
            4'd11: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                pw = p;
                mhi = pw[63:32];
                mlo = pw[31:0];
                res = mlo;
            end
            4'd12: begin
                if (b == 32'd0) begin
                    mlo = '1;
                    mhi = a;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    pw = q;
                    mlo = pw[31:0];
                    pw = r;
                    mhi = pw[31:0];
                end
                res = mlo;
            end
            4'd13: res = mhi;
            4'd14: res = mlo;
            default: res = '0;
        endcase
        if (op <= 4'd10 || op == 4'd13 || op == 4'd14) mr[ra] = res;
        return res;
    endfunction

    // Issue one command, check handshake/done/bus timing and resulting state
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic [31:0] imm);
        logic [31:0] exp_bus;
        int guard, jd;
        bit md;
        @(negedge clk);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait op=%0d: cmd_ready=%b expected 1", op, cmd_ready);
        end
        exp_bus   = model_exec(op, ra, rb, rc, imm);
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rc    = rc;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_ra    = 4'($urandom);
        cmd_rb    = 4'($urandom);
        cmd_rc    = 4'($urandom);
        cmd_imm   = $urandom;
        md = (op == 4'd11 || op == 4'd12);
        jd = md ? 2 + W : 2;
        for (int j = 0; j <= jd + 1; j++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'(j == jd)) begin
                failures++;
                $display("FAIL done_timing op=%0d cyc=%0d: done=%b expected %b", op, j, done, j == jd);
            end
            checks++;
            if (cmd_ready !== 1'(j > jd)) begin
                failures++;
                $display("FAIL ready_timing op=%0d cyc=%0d: cmd_ready=%b expected %b", op, j, cmd_ready, j > jd);
            end
            if (j == jd && op != 4'd15) begin
                checks++;
                if (bus_out !== exp_bus) begin
                    failures++;
                    $display("FAIL t2_bus op=%0d: bus_out=%h expected %h", op, bus_out, exp_bus);
                end
            end
            if (md && j == 2 + W / 2) begin
                checks++;
                if (bus_out !== 32'd0) begin
                    failures++;
                    $display("FAIL md_bus op=%0d: bus_out=%h expected 0", op, bus_out);
                end
            end
        end
        checks++;
        if (hi !== mhi || lo !== mlo) begin
            failures++;
            $display("FAIL hilo op=%0d: hi=%h lo=%h expected hi=%h lo=%h", op, hi, lo, mhi, mlo);
        end
        for (int r = 0; r < NREG; r++) begin
            dbg_addr = 4'(r);
            #1;
            checks++;
            if (dbg_data !== mr[r]) begin
                failures++;
                $display("FAIL regfile op=%0d R%0d: got %h expected %h", op, r, dbg_data, mr[r]);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || bus_out !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b done=%b bus=%h hi=%h lo=%h expected 1 0 0 0 0",
                     cmd_ready, done, bus_out, hi, lo);
        end
        for (int r = 0; r < NREG; r++) begin
            dbg_addr = 4'(r);
            #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg R%0d: got %h expected 0", r, dbg_data);
            end
        end
    endtask

    // Reset pulse while a command is in flight; state clears and no done follows
    task automatic pulse_reset_and_check(input string tag);
        int seen;
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        model_clear();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_ctrl: ready=%b done=%b expected 1 0", tag, cmd_ready, done);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL %s_hilo: hi=%h lo=%h expected 0 0", tag, hi, lo);
        end
        for (int r = 0; r < NREG; r++) begin
            dbg_addr = 4'(r);
            #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                failures++;
                $display("FAIL %s_reg R%0d: got %h expected 0", tag, r, dbg_data);
            end
        end
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL %s_no_done: saw %0d done pulses expected 0", tag, seen);
        end
    endtask

    task automatic start_only(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [3:0] rc);
        @(negedge clk);
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_busy_reset;
        do_cmd(4'd10, 4'd1, 4'd0, 4'd0, 32'd5);
        do_cmd(4'd10, 4'd2, 4'd0, 4'd0, 32'h1234);
        do_cmd(4'd11, 4'd0, 4'd1, 4'd2, 32'd0);
        start_only(4'd0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        pulse_reset_and_check("busy_reset");
    endtask

    task automatic expect_reg(input logic [3:0] r, input logic [31:0] v, input string tag);
        dbg_addr = r;
        #1;
        checks++;
        if (dbg_data !== v) begin
            failures++;
            $display("FAIL %s: R%0d=%h expected %h", tag, r, dbg_data, v);
        end
    endtask

    task automatic test_addi_add;
        do_cmd(4'd10, 4'd1, 4'd0, 4'd0, 32'd5);
        expect_reg(4'd1, 32'd5, "addi_r1");
        do_cmd(4'd10, 4'd2, 4'd0, 4'd0, 32'hFFFFFFFD);
        expect_reg(4'd2, 32'hFFFFFFFD, "addi_r2");
        do_cmd(4'd0, 4'd3, 4'd1, 4'd2, 32'd0);
        expect_reg(4'd3, 32'd2, "add_r3");
    endtask

    task automatic test_r0;
        do_cmd(4'd10, 4'd0, 4'd0, 4'd0, 32'd7);
        expect_reg(4'd0, 32'd7, "r0_write");
        do_cmd(4'd10, 4'd7, 4'd0, 4'd0, 32'd1);
        expect_reg(4'd7, 32'd1, "addi_base_zero");
        do_cmd(4'd0, 4'd8, 4'd0, 4'd0, 32'd0);
        expect_reg(4'd8, 32'd14, "add_r0_read");
    endtask

    task automatic test_shift;
        do_cmd(4'd10, 4'd4, 4'd0, 4'd0, 32'h80000001);
        do_cmd(4'd6, 4'd5, 4'd4, 4'd1, 32'd0);
        expect_reg(4'd5, 32'h0C000000, "ror");
        do_cmd(4'd4, 4'd6, 4'd4, 4'd1, 32'd0);
        expect_reg(4'd6, 32'h04000000, "shr");
        do_cmd(4'd7, 4'd9, 4'd4, 4'd1, 32'd0);
        expect_reg(4'd9, 32'h00000030, "rol");
    endtask

    task automatic test_mul;
        do_cmd(4'd11, 4'd0, 4'd1, 4'd2, 32'd0);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL mul_5x-3: hi=%h lo=%h expected ffffffff fffffff1", hi, lo);
        end
        do_cmd(4'd14, 4'd10, 4'd0, 4'd0, 32'd0);
        expect_reg(4'd10, 32'hFFFFFFF1, "mflo");
        do_cmd(4'd13, 4'd11, 4'd0, 4'd0, 32'd0);
        expect_reg(4'd11, 32'hFFFFFFFF, "mfhi");
    endtask

    task automatic test_div;
        do_cmd(4'd10, 4'd11, 4'd0, 4'd0, 32'hFFFFFFF9);
        do_cmd(4'd10, 4'd12, 4'd0, 4'd0, 32'd2);
        do_cmd(4'd12, 4'd0, 4'd11, 4'd12, 32'd0);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL div_-7/2: lo=%h hi=%h expected fffffffd ffffffff", lo, hi);
        end
        do_cmd(4'd10, 4'd13, 4'd0, 4'd0, 32'd9);
        do_cmd(4'd10, 4'd14, 4'd0, 4'd0, 32'd0);
        do_cmd(4'd12, 4'd0, 4'd13, 4'd14, 32'd0);
        checks++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'd9) begin
            failures++;
            $display("FAIL div_by_zero: lo=%h hi=%h expected ffffffff 00000009", lo, hi);
        end
        do_cmd(4'd10, 4'd13, 4'd0, 4'd0, 32'h80000000);
        do_cmd(4'd10, 4'd14, 4'd0, 4'd0, 32'hFFFFFFFF);
        do_cmd(4'd12, 4'd0, 4'd13, 4'd14, 32'd0);
        checks++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            failures++;
            $display("FAIL div_min_by_-1: lo=%h hi=%h expected 80000000 00000000", lo, hi);
        end
        do_cmd(4'd15, 4'd3, 4'd1, 4'd2, 32'd0);
    endtask

    task automatic test_div_reset;
        do_cmd(4'd10, 4'd11, 4'd0, 4'd0, 32'hFFFFFFF9);
        do_cmd(4'd12, 4'd0, 4'd11, 4'd12, 32'd0);
        start_only(4'd12, 4'd0, 4'd11, 4'd12);
        repeat (10) @(negedge clk);
        pulse_reset_and_check("div_reset");
    endtask

    task automatic test_random;
        for (int r = 1; r < NREG; r++)
            do_cmd(4'd10, 4'(r), 4'd0, 4'd0, $urandom);
        for (int n = 0; n < 80; n++) begin
            logic [31:0] imm;
            imm = (n % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), imm);
        end
    endtask

    initial begin
        model_clear();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        test_reset();
        test_busy_reset();
        test_addi_add();
        test_r0();
        test_shift();
        test_mul();
        test_div();
        test_div_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
